i2c_bit_sequencer: RTL and testbench

- Byte-level I2C master controller that sequences START, WRITE-byte, READ-byte and STOP bus conditions on open-drain SCL/SDA.
- Sits between the host-side command interface of the I2C core and the bus pads.
- Generates its own quarter-bit timing from the 50 MHz system clock and supports slave clock stretching.

---
 rtl/i2c_bit_sequencer_if.sv | 28 ++
 rtl/i2c_bit_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_bit_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bit_sequencer_if.sv
// rtl/i2c_bit_sequencer_if.sv - host command and open-drain pad bundle for the I2C bit sequencer
// master = host/pad side, slave = sequencer side.
interface i2c_bit_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       ack_in;
    logic [7:0] rd_data;
    logic       ack_rx;
    logic       done;
    logic       err;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    modport master (
        output cmd_valid, cmd, tx_data, ack_in, scl_in, sda_in,
        input  cmd_ready, rd_data, ack_rx, done, err, busy, scl_oe, sda_oe
    );

    modport slave (
        input  cmd_valid, cmd, tx_data, ack_in, scl_in, sda_in,
        output cmd_ready, rd_data, ack_rx, done, err, busy, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_bit_sequencer.sv
// rtl/i2c_bit_sequencer.sv - byte-level I2C master sequencing START/WRITE/READ/STOP on open-drain pads
// Every bit is four quarter-bit phases of CLK_DIV clocks; a released SCL held low by a slave freezes timing.
module i2c_bit_sequencer #(
    parameter int CLK_DIV = 125
) (
    input  logic               clk,
    input  logic               reset,
    i2c_bit_sequencer_if.slave bus
);

    localparam int             CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_REJECT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     qtr_q, qtr_d;
    logic [3:0]     bit_q, bit_d;
    logic           pre_q, pre_d;
    logic           owned_q, owned_d;
    logic           rej_q, rej_d;
    logic           sda_last_q, sda_last_d;
    logic [1:0]     op_q, op_d;
    logic [8:0]     tx_q, tx_d;
    logic [8:0]     rx_q, rx_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           ack_rx_q, ack_rx_d;

    logic           scl_oe_c;
    logic           sda_oe_c;
    logic           busy_c;
    logic           accept;
    logic           active;
    logic           freeze;
    logic           tick;

    assign accept = bus.cmd_valid && !busy_c;
    assign active = (state_q == S_START) || (state_q == S_BIT) || (state_q == S_STOP);
    // A slave holding a released SCL low stretches the current quarter indefinitely.
    assign freeze = active && !scl_oe_c && !bus.scl_in;
    assign tick   = active && !freeze && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            pre_q      <= 1'b0;
            owned_q    <= 1'b0;
            rej_q      <= 1'b0;
            sda_last_q <= 1'b0;
            op_q       <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            ack_rx_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            pre_q      <= pre_d;
            owned_q    <= owned_d;
            rej_q      <= rej_d;
            sda_last_q <= sda_last_d;
            op_q       <= op_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            ack_rx_q   <= ack_rx_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        pre_d      = pre_q;
        owned_d    = owned_q;
        rej_d      = rej_q;
        op_d       = op_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        ack_rx_d   = ack_rx_q;
        sda_last_d = sda_oe_c;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    qtr_d = '0;
                    bit_d = '0;
                    rej_d = 1'b0;
                    rx_d  = '0;
                    op_d  = bus.cmd;
                    case (bus.cmd)
                        CMD_START: begin
                            state_d = S_START;
                            pre_d   = owned_q;
                        end
                        CMD_WRITE: begin
                            // Trailing 1 releases SDA for the slave's ACK.
                            tx_d    = {bus.tx_data, 1'b1};
                            state_d = owned_q ? S_BIT : S_REJECT;
                        end
                        CMD_READ: begin
                            tx_d    = {8'hFF, bus.ack_in};
                            state_d = owned_q ? S_BIT : S_REJECT;
                        end
                        default: begin
                            state_d = owned_q ? S_STOP : S_REJECT;
                        end
                    endcase
                end
            end

            S_START, S_BIT, S_STOP: begin
                if (!freeze) begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                end
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (state_q)
                        S_START: begin
                            if (pre_q) begin
                                pre_d = 1'b0;
                                qtr_d = qtr_q;
                            end else if (qtr_q == 2'd3) begin
                                state_d = S_DONE;
                                owned_d = 1'b1;
                            end
                        end
                        S_BIT: begin
                            if (qtr_q == 2'd1) begin
                                rx_d = {rx_q[7:0], bus.sda_in};
                            end
                            if (qtr_q == 2'd3) begin
                                tx_d = {tx_q[7:0], 1'b1};
                                if (bit_q == 4'd8) begin
                                    state_d = S_DONE;
                                    if (op_q == CMD_READ) begin
                                        rd_data_d = rx_q[8:1];
                                    end else begin
                                        ack_rx_d = rx_q[0];
                                    end
                                end else begin
                                    bit_d = bit_q + 4'd1;
                                end
                            end
                        end
                        default: begin
                            if (qtr_q == 2'd3) begin
                                state_d = S_DONE;
                                owned_d = 1'b0;
                            end
                        end
                    endcase
                end
            end

            S_REJECT: begin
                state_d = S_DONE;
                rej_d   = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs; outside a bus phase an owned bus parks SCL low with SDA at its last level.
    always_comb begin
        scl_oe_c = owned_q;
        sda_oe_c = owned_q & sda_last_q;
        case (state_q)
            S_START: begin
                if (pre_q) begin
                    scl_oe_c = 1'b1;
                    sda_oe_c = 1'b0;
                end else begin
                    scl_oe_c = (qtr_q == 2'd3);
                    sda_oe_c = qtr_q[1];
                end
            end
            S_BIT: begin
                scl_oe_c = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_oe_c = ~tx_q[8];
            end
            S_STOP: begin
                scl_oe_c = (qtr_q == 2'd0);
                sda_oe_c = ~qtr_q[1];
            end
            default: begin
            end
        endcase
    end

    assign busy_c        = (state_q != S_IDLE);
    assign bus.busy      = busy_c;
    assign bus.cmd_ready = ~busy_c;
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = (state_q == S_DONE) && rej_q;
    assign bus.scl_oe    = scl_oe_c;
    assign bus.sda_oe    = sda_oe_c;
    assign bus.rd_data   = rd_data_q;
    assign bus.ack_rx    = ack_rx_q;

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// tb/tb_i2c_bit_sequencer.sv - scoreboard bench for i2c_bit_sequencer with a simple slave/pad model
module tb_i2c_bit_sequencer;

    localparam int CLK_DIV = 4;
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2c_bit_sequencer_if bus();

    i2c_bit_sequencer #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic slave_sda_low = 1'b0;
    logic stretch_low   = 1'b0;
    assign bus.scl_in = ~(bus.scl_oe | stretch_low);
    assign bus.sda_in = ~(bus.sda_oe | slave_sda_low);

    typedef struct {
        string      name;
        int         acc;
        int         lat;
        logic       err;
        logic [7:0] rd;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Bus observer state
    logic sda_bits[$];
    int   rises = 0, start_seen = 0, stop_seen = 0, oe_cnt = 0, sda_drv = 0;
    int   stretch_left = 0;
    logic stretch_armed = 1'b0;

    // Slave behaviour selected by the stimulus
    int         slave_mode = 0;
    logic       ack_pull   = 1'b0;
    logic [7:0] rd_byte    = 8'h00;
    logic       stretch_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pack_bits();
        logic [31:0] v = '0;
        foreach (sda_bits[i]) v = {v[30:0], sda_bits[i]};
        return v;
    endfunction

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected none pending");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_latency"}, cyc - e.acc, e.lat);
                    chk({e.name, "_err"}, bus.err, e.err);
                    chk({e.name, "_rd_data"}, bus.rd_data, e.rd);
                    chk({e.name, "_ack_rx"}, bus.ack_rx, e.ack);
                end
            end
        end
    end

    // Pad observer, slave data/ACK driver and clock stretcher
    initial begin
        logic sc, sd, prev_scl, prev_sda, prev_busy;
        prev_scl  = 1'b1;
        prev_sda  = 1'b1;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            sc = bus.scl_in;
            sd = bus.sda_in;
            if (bus.busy && !prev_busy) begin
                sda_bits.delete();
                rises         = 0;
                start_seen    = 0;
                stop_seen     = 0;
                oe_cnt        = 0;
                sda_drv       = 0;
                stretch_left  = stretch_en ? 50 : 0;
                stretch_armed = 1'b0;
            end
            if (!prev_scl && sc) begin
                sda_bits.push_back(sd);
                rises++;
            end
            if (prev_scl && sc && prev_sda && !sd) start_seen++;
            if (prev_scl && sc && !prev_sda && sd) stop_seen++;
            if (bus.scl_oe || bus.sda_oe) oe_cnt++;
            if (bus.busy && bus.sda_oe) sda_drv++;
            if (bus.scl_oe) begin
                case (slave_mode)
                    1: slave_sda_low = ack_pull && (rises == 8);
                    2: if (rises < 8) slave_sda_low = !rd_byte[7 - rises];
                       else slave_sda_low = 1'b0;
                    default: slave_sda_low = 1'b0;
                endcase
            end
            if (bus.busy && stretch_left > 0 && rises == 3 && bus.scl_oe) stretch_armed = 1'b1;
            if (stretch_armed && stretch_left > 0) begin
                stretch_low = 1'b1;
                if (!bus.scl_oe) stretch_left--;
            end else begin
                stretch_low = 1'b0;
            end
            if (reset) begin
                slave_sda_low = 1'b0;
                stretch_low   = 1'b0;
            end
            prev_scl  = sc;
            prev_sda  = sd;
            prev_busy = bus.busy;
        end
    end

    task automatic issue(input string name, input logic [1:0] c, input logic [7:0] d, input logic a,
                         input int lat, input logic err, input logic [7:0] rd, input logic ack);
        exp_t e;
        int   n = 0;
        while (!bus.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.tx_data   = d;
        bus.ack_in    = a;
        e.name = name;
        e.acc  = cyc;
        e.lat  = lat;
        e.err  = err;
        e.rd   = rd;
        e.ack  = ack;
        exp_q.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.tx_data   = 8'h00;
        bus.ack_in    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_scl_oe", bus.scl_oe, 0);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rd_data", bus.rd_data, 8'h00);
        chk("rst_ack_rx", bus.ack_rx, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);

        issue("wr_unowned", C_WRITE, 8'h12, 1'b1, 2, 1'b1, 8'h00, 1'b0);
        wait_idle("wr_unowned");
        chk("wr_unowned_bus_quiet", oe_cnt, 0);

        issue("start", C_START, 8'h00, 1'b1, 17, 1'b0, 8'h00, 1'b0);
        wait_idle("start");
        chk("start_condition", start_seen, 1);
        chk("owned_idle_scl_low", bus.scl_oe, 1);
        chk("owned_idle_sda_held", bus.sda_oe, 1);

        slave_mode = 1;
        ack_pull   = 1'b1;
        issue("wr_a5", C_WRITE, 8'hA5, 1'b1, 145, 1'b0, 8'h00, 1'b0);
        wait_idle("wr_a5");
        chk("wr_a5_bit_count", sda_bits.size(), 9);
        chk("wr_a5_sda_at_rise", pack_bits(), 32'h14A);

        slave_mode = 0;
        issue("rstart", C_START, 8'h00, 1'b1, 21, 1'b0, 8'h00, 1'b0);
        chk("rstart_prefix_scl", bus.scl_oe, 1);
        chk("rstart_prefix_sda", bus.sda_oe, 0);
        wait_idle("rstart");
        chk("rstart_condition", start_seen, 1);

        slave_mode = 2;
        rd_byte    = 8'h3C;
        issue("rd_3c", C_READ, 8'h00, 1'b1, 145, 1'b0, 8'h3C, 1'b0);
        wait_idle("rd_3c");
        chk("rd_3c_sda_released", sda_drv, 0);
        chk("rd_3c_bit_count", sda_bits.size(), 9);

        slave_mode = 0;
        issue("stop", C_STOP, 8'h00, 1'b1, 17, 1'b0, 8'h3C, 1'b0);
        wait_idle("stop");
        chk("stop_condition", stop_seen, 1);
        chk("stop_idle_scl", bus.scl_oe, 0);
        chk("stop_idle_sda", bus.sda_oe, 0);

        issue("wr_after_stop", C_WRITE, 8'h77, 1'b1, 2, 1'b1, 8'h3C, 1'b0);
        wait_idle("wr_after_stop");
        chk("wr_after_stop_bus_quiet", oe_cnt, 0);

        issue("start2", C_START, 8'h00, 1'b1, 17, 1'b0, 8'h3C, 1'b0);
        wait_idle("start2");

        slave_mode = 1;
        ack_pull   = 1'b0;
        stretch_en = 1'b1;
        issue("wr_ff_stretch", C_WRITE, 8'hFF, 1'b1, 195, 1'b0, 8'h3C, 1'b1);
        wait_idle("wr_ff_stretch");
        stretch_en = 1'b0;
        chk("wr_ff_stretch_used", stretch_left, 0);
        chk("wr_ff_bit_count", sda_bits.size(), 9);
        chk("wr_ff_sda_at_rise", pack_bits(), 32'h1FF);

        ack_pull = 1'b1;
        issue("wr_reset", C_WRITE, 8'h55, 1'b1, 145, 1'b0, 8'h3C, 1'b0);
        repeat (58) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("midrst_scl_oe", bus.scl_oe, 0);
        chk("midrst_sda_oe", bus.sda_oe, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_rd_data", bus.rd_data, 8'h00);
        reset = 1'b0;
        slave_mode = 0;
        @(negedge clk);

        issue("wr_after_reset", C_WRITE, 8'h99, 1'b1, 2, 1'b1, 8'h00, 1'b0);
        wait_idle("wr_after_reset");
        chk("wr_after_reset_bus_quiet", oe_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
